pe_operand_collector: RTL and testbench
=======================================

Name: pe_operand_collector

Overview:
- Upstream operand-join stage of a PE. Feeds operands to the PE functional unit (the divider-capable FU wrapper) through its a_i/b_i/ops_valid_i/ready_o interface.
- Buffers operand A and operand B, each arriving on its own valid/ready channel from neighbour PEs or the streaming fabric, in independent small FIFOs.
- Substitutes the loopback result for A and the configured constant for B when selected.
- Presents a joined operand pair with a single valid, gated by FU readiness.

Parameters:
N_BITS, 32, operand data width
DEPTH, 2, entries per operand FIFO; power of two, at least 2
CNT_W, 16, width of the stall counter

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear on reconfiguration
a_valid_i  in  1  operand A valid
a_data_i  in  N_BITS  operand A data
a_ready_o  out  1  A FIFO can accept
b_valid_i  in  1  operand B valid
b_data_i  in  N_BITS  operand B data
b_ready_o  out  1  B FIFO can accept
loopback_i  in  1  A taken from loopback_data_i (driven by FU acc_loopback_o)
loopback_data_i  in  N_BITS  fed-back FU result
b_sel_const_i  in  1  B taken from const_i (static per configuration)
const_i  in  N_BITS  configured constant
fu_ready_i  in  1  FU ready_o
ops_valid_o  out  1  joined operand pair valid (to FU ops_valid_i)
a_o  out  N_BITS  operand A to FU
b_o  out  N_BITS  operand B to FU
a_count_o  out  $clog2(DEPTH)+1  A FIFO occupancy
b_count_o  out  $clog2(DEPTH)+1  B FIFO occupancy
stall_cnt_o  out  CNT_W  saturating count of cycles with ops_valid_o=1 and fu_ready_i=0

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - Pointers, counts, storage and stall_cnt_o clear to 0.
  - ops_valid_o=0, a_o=b_o=0.
  - a_ready_o=b_ready_o=1 one cycle after release.
  - Reset mid-transfer discards all buffered operands.
- FIFOs (one each for A and B, identical):
  - Circular buffer with read/write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty at wrap-around.
  - x_ready_o = !full. It does not depend on the same-cycle pop, so there is no ready-to-ready combinational path.
  - Push when x_valid_i && x_ready_o.
  - Heads are read from registered storage. Data pushed in cycle t is visible on a_o/b_o in cycle t+1, so minimum latency is 1 cycle.
  - A push to an empty FIFO is never popped in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Operand availability:
  - a_avail = loopback_i ? 1 : A not empty.
  - b_avail = b_sel_const_i ? 1 : B not empty.
  - a_o = loopback_i ? loopback_data_i : A head. b_o = b_sel_const_i ? const_i : B head.
  - Empty-FIFO heads output the last stored word. a_o/b_o are don't-care when ops_valid_o=0.
- Join:
  - ops_valid_o = a_avail && b_avail. It is independent of fu_ready_i (valid never waits on ready).
  - fire = ops_valid_o && fu_ready_i.
  - On fire, pop A unless loopback_i, and pop B unless b_sel_const_i.
  - When a source is substituted, its FIFO is held but may still fill, and drains once substitution is deselected.
  - With both substitutions active, ops_valid_o=1 permanently and a pair fires on every fu_ready_i cycle.
- Stall counter:
  - Increments when ops_valid_o && !fu_ready_i.
  - Saturates at 2^CNT_W-1 without wrapping.
  - Cleared by flush_i.
- flush_i:
  - Clears pointers, counts and stall_cnt_o at the next edge.
  - Has priority over a same-cycle push or pop; the push is dropped and the pop does not occur.
  - ops_valid_o still evaluates combinationally in the flush cycle. The FU must not rely on that cycle; configuration holds fu_ready_i low during flush.
- Substitution selects may change only between configurations, except loopback_i, which toggles at accumulation start and end. Its effect is combinational in the same cycle.

Test Plan:
1. Reset release, then a single A=5 and B=7 pushed in cycle 0 with fu_ready_i=1 -> ops_valid_o=1 in cycle 1 with a_o=5, b_o=7; pair pops, ops_valid_o=0 in cycle 2; counts return to 0.
2. Push A=1,2,3 back-to-back with no B and DEPTH=2 -> a_ready_o drops after 2 accepts and the third is held; a_count_o=2; ops_valid_o=0. Then push B=10,20 with fu_ready_i=1 -> pairs (1,10),(2,20) in consecutive cycles; A=3 is then accepted.
3. fu_ready_i=0 for 5 cycles with a valid pair present -> stall_cnt_o=5, outputs stable, no pops. With CNT_W=4 and 20 stall cycles -> stall_cnt_o saturates at 15.
4. loopback_i=1, loopback_data_i=100, B stream 1,2,3 -> pairs (100,1),(100,2),(100,3); A FIFO occupancy unchanged throughout.
5. b_sel_const_i=1, const_i=9, A stream 4,6 -> pairs (4,9),(6,9); B pushes still fill the B FIFO to DEPTH and are not consumed.
6. FIFOs full, then flush_i asserted together with a_valid_i -> counts=0 next cycle, the pushed word is dropped, and ops_valid_o=0 afterwards. Separately, rst_n_i asserted mid-stream -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/pe_operand_collector.sv
// Operand-join stage ahead of the PE functional unit.
// Operand A and operand B each get their own small FIFO. Either source can be
// replaced: A by the loopback result, B by the configured constant. The joined
// pair is presented to the FU with a single valid signal.

// Circular-buffer FIFO, one instance per operand.
// The extra MSB on each pointer tells full apart from empty after wrap-around.
module pe_oc_fifo #(
   parameter int N_BITS = 32,
   parameter int DEPTH  = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [N_BITS-1:0]        data_i,
   input  logic                     pop_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [N_BITS-1:0]        head_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]                  wr_ptr, rd_ptr;
   logic [DEPTH-1:0][N_BITS-1:0] mem;
   logic [AW-1:0]                rd_prev;

   assign empty_o = (wr_ptr == rd_ptr);
   assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count_o = wr_ptr - rd_ptr;
   assign rd_prev = rd_ptr[AW-1:0] - AW'(1);
   // When the FIFO is empty, show the word that was written last.
   assign head_o  = empty_o ? mem[rd_prev] : mem[rd_ptr[AW-1:0]];

   // Pointer and storage update. A flush takes priority over push and pop.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         mem    <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_i && !full_o) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop_i && !empty_o)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
endmodule

module pe_operand_collector #(
   parameter int N_BITS = 32,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   flush_i,
   input  logic                   a_valid_i,
   input  logic [N_BITS-1:0]      a_data_i,
   output logic                   a_ready_o,
   input  logic                   b_valid_i,
   input  logic [N_BITS-1:0]      b_data_i,
   output logic                   b_ready_o,
   input  logic                   loopback_i,
   input  logic [N_BITS-1:0]      loopback_data_i,
   input  logic                   b_sel_const_i,
   input  logic [N_BITS-1:0]      const_i,
   input  logic                   fu_ready_i,
   output logic                   ops_valid_o,
   output logic [N_BITS-1:0]      a_o,
   output logic [N_BITS-1:0]      b_o,
   output logic [$clog2(DEPTH):0] a_count_o,
   output logic [$clog2(DEPTH):0] b_count_o,
   output logic [CNT_W-1:0]       stall_cnt_o
);
   logic              run_q;
   logic              a_full, a_empty, b_full, b_empty;
   logic [N_BITS-1:0] a_head, b_head;
   logic              a_avail, b_avail, fire;

   // run_q keeps every output at 0 while reset is asserted and sets ready
   // one cycle after reset is released.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) run_q <= 1'b0;
      else          run_q <= 1'b1;
   end

   // a_ready_o and b_ready_o depend only on the registered full flag, so there
   // is no combinational path from FU ready to upstream ready.
   assign a_ready_o = run_q && !a_full;
   assign b_ready_o = run_q && !b_full;

   assign a_avail     = loopback_i    || !a_empty;
   assign b_avail     = b_sel_const_i || !b_empty;
   assign ops_valid_o = run_q && a_avail && b_avail;
   assign fire        = ops_valid_o && fu_ready_i;

   assign a_o = !run_q ? '0 : (loopback_i    ? loopback_data_i : a_head);
   assign b_o = !run_q ? '0 : (b_sel_const_i ? const_i         : b_head);

   pe_oc_fifo #(.N_BITS(N_BITS), .DEPTH(DEPTH)) u_a_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (flush_i),
      .push_i  (a_valid_i && a_ready_o),
      .data_i  (a_data_i),
      .pop_i   (fire && !loopback_i),
      .full_o  (a_full),
      .empty_o (a_empty),
      .head_o  (a_head),
      .count_o (a_count_o)
   );

   pe_oc_fifo #(.N_BITS(N_BITS), .DEPTH(DEPTH)) u_b_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (flush_i),
      .push_i  (b_valid_i && b_ready_o),
      .data_i  (b_data_i),
      .pop_i   (fire && !b_sel_const_i),
      .full_o  (b_full),
      .empty_o (b_empty),
      .head_o  (b_head),
      .count_o (b_count_o)
   );

   // Count the cycles in which a pair is valid but the FU is not ready.
   // The count saturates at its maximum value and a flush clears it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         stall_cnt_o <= '0;
      else if (flush_i)
         stall_cnt_o <= '0;
      else if (ops_valid_o && !fu_ready_i && (stall_cnt_o != '1))
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
   end
endmodule

// File: tb/tb_pe_operand_collector.sv
// Directed bench for pe_operand_collector.
// Inputs are driven 1 ns after each rising edge, and outputs are sampled at
// that same point.
module tb_pe_operand_collector;
   localparam int N_BITS = 32;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = 4;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              clk_i = 1'b0;
   logic              rst_n_i, flush_i;
   logic              a_valid_i, b_valid_i, a_ready_o, b_ready_o;
   logic [N_BITS-1:0] a_data_i, b_data_i, loopback_data_i, const_i, a_o, b_o;
   logic              loopback_i, b_sel_const_i, fu_ready_i, ops_valid_o;
   logic [CW-1:0]     a_count_o, b_count_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   pe_operand_collector #(.N_BITS(N_BITS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
      .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
      .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
      .loopback_i(loopback_i), .loopback_data_i(loopback_data_i),
      .b_sel_const_i(b_sel_const_i), .const_i(const_i),
      .fu_ready_i(fu_ready_i), .ops_valid_o(ops_valid_o),
      .a_o(a_o), .b_o(b_o), .a_count_o(a_count_o), .b_count_o(b_count_o),
      .stall_cnt_o(stall_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pair(input string tag, input logic [31:0] ea, input logic [31:0] eb);
      chk({tag, " valid"}, 64'(ops_valid_o), 64'd1);
      chk({tag, " a"}, 64'(a_o), 64'(ea));
      chk({tag, " b"}, 64'(b_o), 64'(eb));
   endtask

   task automatic flush();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
   endtask

   initial begin
      rst_n_i = 1'b0; flush_i = 1'b0;
      a_valid_i = 1'b0; b_valid_i = 1'b0; a_data_i = '0; b_data_i = '0;
      loopback_i = 1'b0; loopback_data_i = '0; b_sel_const_i = 1'b0; const_i = '0;
      fu_ready_i = 1'b1;
      step(); step();
      chk("rst valid", 64'(ops_valid_o), 64'd0);
      chk("rst a_ready", 64'(a_ready_o), 64'd0);
      chk("rst stall", 64'(stall_cnt_o), 64'd0);
      rst_n_i = 1'b1;
      step();
      chk("rel a_ready", 64'(a_ready_o), 64'd1);
      chk("rel b_ready", 64'(b_ready_o), 64'd1);

      // 1: single pair, one-cycle latency
      a_valid_i = 1; a_data_i = 5; b_valid_i = 1; b_data_i = 7;
      chk("t1 same-cycle valid", 64'(ops_valid_o), 64'd0);
      step();
      a_valid_i = 0; b_valid_i = 0;
      pair("t1 pair", 5, 7);
      chk("t1 a_count", 64'(a_count_o), 64'd1);
      step();
      chk("t1 drained valid", 64'(ops_valid_o), 64'd0);
      chk("t1 a_count0", 64'(a_count_o), 64'd0);
      chk("t1 b_count0", 64'(b_count_o), 64'd0);

      // 2: A backpressure, then paired drain
      a_valid_i = 1; a_data_i = 1; step();
      a_data_i = 2; step();
      a_data_i = 3;
      chk("t2 a_ready full", 64'(a_ready_o), 64'd0);
      step();
      chk("t2 a_count", 64'(a_count_o), 64'd2);
      chk("t2 no pair", 64'(ops_valid_o), 64'd0);
      b_valid_i = 1; b_data_i = 10; step();
      b_data_i = 20;
      pair("t2 pair1", 1, 10);
      chk("t2 a_ready still 0", 64'(a_ready_o), 64'd0);
      step();
      b_valid_i = 0;
      pair("t2 pair2", 2, 20);
      chk("t2 a_ready back", 64'(a_ready_o), 64'd1);
      step();
      a_valid_i = 0;
      chk("t2 a3 accepted", 64'(a_count_o), 64'd1);
      chk("t2 b_count0", 64'(b_count_o), 64'd0);
      chk("t2 b empty valid", 64'(ops_valid_o), 64'd0);
      flush();
      chk("t2 flush count", 64'(a_count_o), 64'd0);

      // 3: stall counting and saturation
      fu_ready_i = 0;
      a_valid_i = 1; a_data_i = 11; b_valid_i = 1; b_data_i = 22;
      step();
      a_valid_i = 0; b_valid_i = 0;
      chk("t3 stall start", 64'(stall_cnt_o), 64'd0);
      for (int i = 0; i < 5; i++) step();
      chk("t3 stall5", 64'(stall_cnt_o), 64'd5);
      pair("t3 held", 11, 22);
      chk("t3 a_count", 64'(a_count_o), 64'd1);
      chk("t3 b_count", 64'(b_count_o), 64'd1);
      for (int i = 0; i < 15; i++) step();
      chk("t3 stall sat", 64'(stall_cnt_o), 64'd15);
      fu_ready_i = 1; step();
      chk("t3 popped", 64'(ops_valid_o), 64'd0);
      chk("t3 stall kept", 64'(stall_cnt_o), 64'd15);
      flush();
      chk("t3 stall flushed", 64'(stall_cnt_o), 64'd0);

      // 4: loopback substitutes A
      loopback_i = 1; loopback_data_i = 100;
      chk("t4 no B", 64'(ops_valid_o), 64'd0);
      a_valid_i = 1; a_data_i = 50; b_valid_i = 1; b_data_i = 1;
      step();
      a_valid_i = 0; b_data_i = 2;
      pair("t4 p1", 100, 1);
      chk("t4 a_count1", 64'(a_count_o), 64'd1);
      step();
      b_data_i = 3;
      pair("t4 p2", 100, 2);
      step();
      b_valid_i = 0;
      pair("t4 p3", 100, 3);
      step();
      chk("t4 end valid", 64'(ops_valid_o), 64'd0);
      chk("t4 a held", 64'(a_count_o), 64'd1);
      loopback_i = 0;
      flush();

      // 5: constant substitutes B; the B FIFO still fills
      b_sel_const_i = 1; const_i = 9;
      a_valid_i = 1; a_data_i = 4; b_valid_i = 1; b_data_i = 77;
      step();
      a_data_i = 6; b_data_i = 78;
      pair("t5 p1", 4, 9);
      chk("t5 b_count1", 64'(b_count_o), 64'd1);
      step();
      a_valid_i = 0; b_data_i = 79;
      pair("t5 p2", 6, 9);
      chk("t5 b_count2", 64'(b_count_o), 64'd2);
      chk("t5 b_ready", 64'(b_ready_o), 64'd0);
      step();
      b_valid_i = 0;
      chk("t5 end valid", 64'(ops_valid_o), 64'd0);
      chk("t5 b_count kept", 64'(b_count_o), 64'd2);
      b_sel_const_i = 0;
      flush();

      // 6a: flush with full FIFOs and a concurrent push
      fu_ready_i = 0;
      a_valid_i = 1; b_valid_i = 1; a_data_i = 1; b_data_i = 3; step();
      a_data_i = 2; b_data_i = 4; step();
      b_valid_i = 0;
      chk("t6 a full", 64'(a_count_o), 64'd2);
      chk("t6 b full", 64'(b_count_o), 64'd2);
      flush_i = 1; a_data_i = 8; step();
      flush_i = 0; a_valid_i = 0;
      chk("t6 a flushed", 64'(a_count_o), 64'd0);
      chk("t6 b flushed", 64'(b_count_o), 64'd0);
      chk("t6 valid off", 64'(ops_valid_o), 64'd0);
      chk("t6 stall cleared", 64'(stall_cnt_o), 64'd0);
      // 6b: flush drops a push into a non-full FIFO
      a_valid_i = 1; a_data_i = 8; flush_i = 1; step();
      flush_i = 0; a_valid_i = 0;
      chk("t6 push dropped", 64'(a_count_o), 64'd0);

      // 6c: asynchronous reset while a pair is waiting
      a_valid_i = 1; a_data_i = 5; b_valid_i = 1; b_data_i = 6; step();
      a_valid_i = 0; b_valid_i = 0;
      pair("t6 pre-reset", 5, 6);
      #2 rst_n_i = 1'b0;
      #1;
      chk("t6 rst valid", 64'(ops_valid_o), 64'd0);
      chk("t6 rst a_o", 64'(a_o), 64'd0);
      chk("t6 rst b_o", 64'(b_o), 64'd0);
      chk("t6 rst a_ready", 64'(a_ready_o), 64'd0);
      chk("t6 rst a_count", 64'(a_count_o), 64'd0);
      chk("t6 rst b_count", 64'(b_count_o), 64'd0);
      step();
      rst_n_i = 1'b1;
      step();
      chk("t6 post a_ready", 64'(a_ready_o), 64'd1);
      chk("t6 post discard", 64'(ops_valid_o), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
